// File: rtl/e1b_code_sched.sv
// E1B code BRAM controller: sequences CPU loading of the shared code memory and
// time-shares its read port round-robin to prefetch each channel's next chip.
module e1b_code_sched #(
  parameter int GPS_CHANS    = 12,
  parameter int E1B_CODEBITS = 12,
  parameter int E1B_CODELEN  = 4092,
  parameter int BRAM_LAT     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ld_start,
  input  logic                                wr,
  input  logic [GPS_CHANS-1:0]                tos,
  output logic                                ld_busy,
  output logic                                ld_done,
  output logic                                code_ready,
  output logic                                wr_err,
  input  logic [GPS_CHANS*E1B_CODEBITS-1:0]   nchip_n,
  input  logic [GPS_CHANS-1:0]                full_chip,
  output logic                                bram_we,
  output logic [E1B_CODEBITS-1:0]             bram_waddr,
  output logic [GPS_CHANS-1:0]                bram_wdata,
  output logic [E1B_CODEBITS-1:0]             bram_raddr,
  input  logic [GPS_CHANS-1:0]                bram_rdata,
  output logic [GPS_CHANS-1:0]                code_o
);

  localparam int CH_W = (GPS_CHANS > 1) ? $clog2(GPS_CHANS) : 1;
  localparam logic [E1B_CODEBITS-1:0] LAST_CHIP = E1B_CODEBITS'(E1B_CODELEN - 1);
  localparam logic [CH_W-1:0]         LAST_CH   = CH_W'(GPS_CHANS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                    state_reg, state_next;
  logic [E1B_CODEBITS-1:0]   waddr_reg, waddr_next;
  logic                      wr_err_reg, wr_err_next;
  logic                      ld_done_reg, ld_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      waddr_reg   <= '0;
      wr_err_reg  <= 1'b0;
      ld_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      waddr_reg   <= waddr_next;
      wr_err_reg  <= wr_err_next;
      ld_done_reg <= ld_done_next;
    end
  end

  // ld_start takes priority over a coincident wr; that word is dropped silently.
  always_comb begin
    state_next   = state_reg;
    waddr_next   = waddr_reg;
    wr_err_next  = wr_err_reg;
    ld_done_next = 1'b0;
    bram_we      = 1'b0;
    if (ld_start) begin
      state_next  = LOAD;
      waddr_next  = '0;
      wr_err_next = 1'b0;
    end else if (wr) begin
      if (state_reg == LOAD) begin
        bram_we = 1'b1;
        if (waddr_reg == LAST_CHIP) begin
          state_next   = READY;
          waddr_next   = '0;
          ld_done_next = 1'b1;
        end else begin
          waddr_next = waddr_reg + E1B_CODEBITS'(1);
        end
      end else begin
        wr_err_next = 1'b1;
      end
    end
  end

  assign ld_busy    = (state_reg == LOAD);
  assign code_ready = (state_reg == READY);
  assign ld_done    = ld_done_reg;
  assign wr_err     = wr_err_reg;
  assign bram_waddr = waddr_reg;
  assign bram_wdata = tos;

  logic [E1B_CODEBITS-1:0] nchip [GPS_CHANS];
  logic [CH_W-1:0]         ch_p_reg;
  logic [E1B_CODEBITS-1:0] cur_chip, next_chip;
  logic [CH_W-1:0]         tag_ch_reg [BRAM_LAT+1];
  logic [BRAM_LAT:0]       tag_v_reg;
  logic [GPS_CHANS-1:0]    pf_reg, pf_next;
  logic [GPS_CHANS-1:0]    code_o_reg, code_o_next;

  assign cur_chip  = nchip[ch_p_reg];
  assign next_chip = (cur_chip == LAST_CHIP) ? '0 : cur_chip + E1B_CODEBITS'(1);

  // The tag rides alongside the read so the returning data lands in the right channel.
  generate
    for (genvar gi = 0; gi < GPS_CHANS; gi++) begin : g_chan
      assign nchip[gi] = nchip_n[gi*E1B_CODEBITS +: E1B_CODEBITS];
      assign pf_next[gi] = (tag_v_reg[BRAM_LAT] && tag_ch_reg[BRAM_LAT] == CH_W'(gi))
                           ? bram_rdata[gi] : pf_reg[gi];
      assign code_o_next[gi] = (full_chip[gi] && code_ready) ? pf_reg[gi] : code_o_reg[gi];
    end
    for (genvar gi = 1; gi <= BRAM_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_ch_reg[gi] <= '0;
          tag_v_reg[gi]  <= 1'b0;
        end else begin
          tag_ch_reg[gi] <= tag_ch_reg[gi-1];
          tag_v_reg[gi]  <= tag_v_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_p_reg      <= '0;
      bram_raddr    <= '0;
      tag_ch_reg[0] <= '0;
      tag_v_reg[0]  <= 1'b0;
      pf_reg        <= '0;
      code_o_reg    <= '0;
    end else begin
      ch_p_reg      <= (ch_p_reg == LAST_CH) ? '0 : ch_p_reg + CH_W'(1);
      bram_raddr    <= next_chip;
      tag_ch_reg[0] <= ch_p_reg;
      tag_v_reg[0]  <= code_ready;
      pf_reg        <= pf_next;
      code_o_reg    <= code_o_next;
    end
  end

  assign code_o = code_o_reg;

endmodule

// File: tb/tb_e1b_code_sched.sv
// Directed self-checking bench for e1b_code_sched with a 2-cycle-latency BRAM model.
module tb_e1b_code_sched;

  localparam int NCH = 12;
  localparam int CB  = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ld_start = 1'b0;
  logic            wr = 1'b0;
  logic [NCH-1:0]  tos = '0;
  logic            ld_busy, ld_done, code_ready, wr_err;
  logic [NCH*CB-1:0] nchip_n;
  logic [NCH-1:0]  full_chip = '0;
  logic            bram_we;
  logic [CB-1:0]   bram_waddr;
  logic [NCH-1:0]  bram_wdata;
  logic [CB-1:0]   bram_raddr;
  logic [NCH-1:0]  bram_rdata;
  logic [NCH-1:0]  code_o;

  logic [CB-1:0]   nchip_a [NCH];
  logic [NCH-1:0]  mem [4096];
  logic [NCH-1:0]  rd1;
  logic            poke = 1'b0;
  int              edge_cnt;
  int              checks = 0;
  int              errors = 0;

  e1b_code_sched dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .wr(wr), .tos(tos),
    .ld_busy(ld_busy), .ld_done(ld_done), .code_ready(code_ready), .wr_err(wr_err),
    .nchip_n(nchip_n), .full_chip(full_chip), .bram_we(bram_we),
    .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_raddr(bram_raddr),
    .bram_rdata(bram_rdata), .code_o(code_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    nchip_n = '0;
    for (int c = 0; c < NCH; c++) nchip_n[c*CB +: CB] = nchip_a[c];
  end

  // BRAM model: two register stages from address to data.
  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    if (poke) mem[8] <= 12'h020;
    rd1        <= mem[bram_raddr];
    bram_rdata <= rd1;
  end

  // Edge counter since reset release; the slot used at edge k is k mod NCH.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            ch;
    logic [CB-1:0] nchip;
    logic [CB-1:0] exp_raddr;
  } raddr_vec_t;

  raddr_vec_t rv [8];

  task automatic set_all(input logic [CB-1:0] v);
    for (int c = 0; c < NCH; c++) nchip_a[c] = v;
  endtask

  task automatic pulse_fc(input logic [NCH-1:0] mask);
    @(negedge clk);
    full_chip = mask;
    @(negedge clk);
    full_chip = '0;
  endtask

  initial begin
    rv[0] = '{3, 12'd4091, 12'd0};
    rv[1] = '{3, 12'd100,  12'd101};
    rv[2] = '{3, 12'd0,    12'd1};
    rv[3] = '{3, 12'd4090, 12'd4091};
    rv[4] = '{3, 12'd4095, 12'd0};
    rv[5] = '{3, 12'd4094, 12'd4095};
    rv[6] = '{0, 12'd2047, 12'd2048};
    rv[7] = '{11, 12'd4091, 12'd0};

    set_all(12'd0);
    #12;
    chk("rst_busy",  {31'd0, ld_busy}, 32'd0);
    chk("rst_ready", {31'd0, code_ready}, 32'd0);
    chk("rst_werr",  {31'd0, wr_err}, 32'd0);
    chk("rst_done",  {31'd0, ld_done}, 32'd0);
    chk("rst_code",  {20'd0, code_o}, 32'd0);
    chk("rst_raddr", {20'd0, bram_raddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load of 4092 words
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    #1;
    chk("ld_busy_on", {30'd0, ld_busy, code_ready}, 32'h2);
    for (int i = 0; i < 4092; i++) begin
      wr  = 1'b1;
      tos = 12'(i);
      #1;
      chk("load_word", {7'd0, bram_we, bram_waddr, bram_wdata}, {7'd0, 1'b1, 12'(i), 12'(i)});
      @(negedge clk);
    end
    wr = 1'b0;
    #1;
    chk("ld_done_pulse", {29'd0, ld_done, code_ready, ld_busy}, 32'h6);
    $display("load: 4092 words, ld_done=%0b code_ready=%0b", ld_done, code_ready);
    @(negedge clk);
    poke = 1'b1;
    #1;
    chk("ld_done_clear", {31'd0, ld_done}, 32'd0);
    @(negedge clk);
    poke = 1'b0;

    // Single-channel prefetch: ch5 at chip 7, word 8 = 12'h020
    nchip_a[5] = 12'd7;
    repeat (20) @(negedge clk);
    pulse_fc(12'h020);
    #1;
    chk("prefetch_ch5", {20'd0, code_o}, 32'h020);
    $display("prefetch ch5: code_o=%03h", code_o);

    // All channels, distinct chips; expected bits hand-computed from word(a)=a, word(8)=020
    nchip_a[0] = 12'd0;    nchip_a[1] = 12'd1;    nchip_a[2]  = 12'd3;    nchip_a[3]  = 12'd4091;
    nchip_a[4] = 12'd15;   nchip_a[5] = 12'd7;    nchip_a[6]  = 12'd63;   nchip_a[7]  = 12'd100;
    nchip_a[8] = 12'd255;  nchip_a[9] = 12'd511;  nchip_a[10] = 12'd1000; nchip_a[11] = 12'd2047;
    repeat (20) @(negedge clk);
    pulse_fc(12'hFFF);
    #1;
    chk("all_chan_A", {20'd0, code_o}, 32'hB77);
    $display("all channels A: code_o=%03h", code_o);

    // Move every channel to chip 4091 (next = 0, word 0); no full_chip -> hold
    set_all(12'd4091);
    repeat (20) @(negedge clk);
    #1;
    chk("hold_no_fc", {20'd0, code_o}, 32'hB77);
    pulse_fc(12'h03F);
    #1;
    chk("partial_fc", {20'd0, code_o}, 32'hB40);
    $display("partial full_chip: code_o=%03h", code_o);

    // Read-address wrap table
    for (int v = 0; v < 8; v++) begin
      int n;
      @(negedge clk);
      nchip_a[rv[v].ch] = rv[v].nchip;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((((edge_cnt - 1) % NCH) != rv[v].ch) && n < 30);
      #1;
      if (n >= 30) chk("raddr_timeout", 32'(n), 32'd0);
      else chk("raddr_next", {20'd0, bram_raddr}, {20'd0, rv[v].exp_raddr});
      $display("raddr vec %0d: ch=%0d nchip=%0d raddr=%0d", v, rv[v].ch, rv[v].nchip, bram_raddr);
      nchip_a[rv[v].ch] = 12'd4091;
    end

    // Overrun in READY, then reload
    @(negedge clk);
    wr = 1'b1;
    #1;
    chk("overrun_we", {31'd0, bram_we}, 32'd0);
    @(negedge clk);
    wr = 1'b0;
    #1;
    chk("overrun_err", {31'd0, wr_err}, 32'd1);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    #1;
    chk("reload_state", {29'd0, wr_err, code_ready, ld_busy}, 32'h1);
    $display("overrun/reload: wr_err=%0b code_ready=%0b", wr_err, code_ready);

    // ld_start and wr together
    wr = 1'b1;
    tos = 12'h5A5;
    #1;
    chk("first_wr", {19'd0, bram_we, bram_waddr}, {19'd0, 1'b1, 12'd0});
    @(negedge clk);
    ld_start = 1'b1;
    #1;
    chk("simul_we", {31'd0, bram_we}, 32'd0);
    @(negedge clk);
    ld_start = 1'b0;
    wr = 1'b0;
    #1;
    chk("simul_state", {18'd0, bram_waddr, wr_err, ld_busy}, {18'd0, 12'd0, 1'b0, 1'b1});
    $display("simultaneous: waddr=%0d wr_err=%0b", bram_waddr, wr_err);

    // Async reset mid-load at waddr 1000
    for (int i = 0; i < 1000; i++) begin
      wr  = 1'b1;
      tos = 12'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    #1;
    chk("pre_reset_waddr", {20'd0, bram_waddr}, 32'd1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {6'd0, ld_busy, ld_done, code_ready, wr_err, code_o, bram_waddr},
        32'd0);
    chk("async_rst_raddr", {20'd0, bram_raddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_idle", {30'd0, ld_busy, code_ready}, 32'd0);
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    #1;
    chk("idle_wr_err", {31'd0, wr_err}, 32'd1);
    $display("async reset: idle, code_ready=%0b wr_err=%0b", code_ready, wr_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
